ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the opposite direction to the existing keyboard receiver. It sends one command byte (e.g. set-LEDs `0xED`, reset `0xFF`, enable `0xF4`) to the keyboard over the same open-drain PS2Clk/PS2Data pair. It runs the inhibit/request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device ACK. It sits beside the receiver in the top level; `busy` gates the receiver while a frame is outgoing.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host types, command bytes and timing defaults
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  localparam int PS2_CLK_HZ_DEF     = 100_000_000;
  localparam int PS2_INHIBIT_US_DEF = 100;
  localparam int PS2_TIMEOUT_US_DEF = 15000;

  // Wire order of a host frame, LSB first: data, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// rtl/ps2_sync.sv - 2-flop synchronizer for PS/2 clock/data plus clock falling-edge pulse
module ps2_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_fall
);

  logic [1:0] r_clk_ff;
  logic [1:0] r_data_ff;
  logic       r_clk_prev;

  // Reset to the idle-high bus level so no false edge appears after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_ff   <= 2'b11;
      r_data_ff  <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_ff   <= {r_clk_ff[0], i_ps2_clk};
      r_data_ff  <= {r_data_ff[0], i_ps2_data};
      r_clk_prev <= r_clk_ff[1];
    end
  end

  assign o_clk_sync  = r_clk_ff[1];
  assign o_data_sync = r_data_ff[1];
  assign o_fall      = r_clk_prev & ~r_clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Optional device watchdog enabled by defining PS2_TX_TIMEOUT_EN.
import ps2_pkg::*;

module ps2_host_tx #(
  parameter int CLK_HZ     = PS2_CLK_HZ_DEF,
  parameter int INHIBIT_US = PS2_INHIBIT_US_DEF,
  parameter int TIMEOUT_US = PS2_TIMEOUT_US_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYC = (CLK_HZ / 1_000_000) * INHIBIT_US;
  localparam int INH_W       = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;

  ps2_tx_state_e r_state;
  logic [9:0]    r_frame;
  logic [3:0]    r_bit_cnt;
  logic [INH_W-1:0] r_inh_cnt;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_clk_oe;
  logic          r_data_oe;

  logic w_clk_sync;
  logic w_data_sync;
  logic w_fall;

  ps2_sync u_sync (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ps2_clk   (ps2_clk_i),
    .i_ps2_data  (ps2_data_i),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_fall      (w_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] r_wdog;
  logic             w_wdog_active;
  assign w_wdog_active = (r_state == ST_REQ) || (r_state == ST_SHIFT) ||
                         (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_US;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_wdog    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (tx_valid) begin
            r_frame   <= ps2_frame(tx_data);
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_INHIBIT;
          end
        end
        // Start bit is asserted one cycle before the clock is released.
        ST_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          if (r_inh_cnt == INH_W'(INHIBIT_CYC - 2)) r_data_oe <= 1'b1;
          if (r_inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
            r_clk_oe <= 1'b0;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_fall) begin
            r_data_oe <= ~r_frame[0];
            r_frame   <= {1'b0, r_frame[9:1]};
            r_bit_cnt <= 4'd1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_fall) begin
            r_data_oe <= ~r_frame[0];
            r_frame   <= {1'b0, r_frame[9:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 4'd9) r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_data_oe <= 1'b0;
          if (w_fall) begin
            if (!w_data_sync) begin
              r_state <= ST_WAIT_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_sync && w_data_sync) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog overrides whatever the state decided this cycle.
      if (!w_wdog_active || w_fall) begin
        r_wdog <= '0;
      end else if (r_wdog == TMO_W'(TIMEOUT_CYC - 1)) begin
        r_wdog    <= '0;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_done    <= 1'b0;
        r_err     <= 1'b1;
        r_ready   <= 1'b1;
        r_busy    <= 1'b0;
        r_state   <= ST_IDLE;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
`endif
    end
  end

  assign tx_ready    = r_ready;
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign busy        = r_busy;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ      = 1_000_000;
  localparam int INHIBIT_US  = 100;
  localparam int TIMEOUT_US  = 15000;
  localparam int INHIBIT_CYC = (CLK_HZ / 1_000_000) * INHIBIT_US;
  localparam int TMO_CYC     = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int HALF        = 40;

  typedef struct {
    logic [7:0] data;
    bit         expect_done;
    bit         check_frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned rts_cycle = 0;
  logic [9:0]  rx_bits;
  bit          dev_ack, dev_mute, bfm_halted;
  int          dev_stop_after;
  int          inh_cnt;
  bit          last_doe, prev_oe;

  assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Device side: clocks the frame at 12.5 kHz-equivalent, samples on rising edges.
  task automatic run_frame();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == dev_stop_after) begin
        bfm_halted = 1'b1;
        return;
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) rx_bits[i] = ps2_data_i;
      if (i == 9 && dev_ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data = 1'b0;
        repeat (HALF - HALF / 2) @(negedge clk);
      end else if (i == 10) begin
        dev_data = 1'b1;
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  initial begin : device_bfm
    inh_cnt = 0; prev_oe = 1'b0; last_doe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        inh_cnt = 0; prev_oe = 1'b0;
      end else if (ps2_clk_oe) begin
        inh_cnt++; last_doe = ps2_data_oe; prev_oe = 1'b1;
      end else if (prev_oe) begin
        prev_oe = 1'b0;
        rts_cycle = cyc;
        check("inhibit_cycles", inh_cnt, INHIBIT_CYC);
        check("start_bit_last_inhibit", last_doe, 1);
        check("start_bit_in_req", ps2_data_oe, 1);
        inh_cnt = 0;
        rx_bits = '0;
        if (!dev_mute) run_frame();
      end
    end
  end

  // Scoreboard monitor: every done/err pulse retires one expected transaction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (tx_done || tx_err)) begin
      check("pulse_has_pending_frame", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [9:0] want;
        e = exp_q.pop_front();
        want = {1'b1, ($countones(e.data) % 2 == 0) ? 1'b1 : 1'b0, e.data};
        check("outcome_done", tx_done, e.expect_done);
        check("outcome_err", tx_err, !e.expect_done);
        check("ready_with_pulse", tx_ready, 1);
        check("busy_cleared", busy, 0);
        if (e.check_frame) begin
          check("frame_bits", rx_bits, want);
        end else begin
          check("timeout_clk_oe", ps2_clk_oe, 0);
          check("timeout_data_oe", ps2_data_oe, 0);
          check("timeout_latency", cyc - rts_cycle, TMO_CYC);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit ack, input bit mute,
                      input bit wait_done, input int bound);
    exp_t e;
    int w;
    dev_ack = ack; dev_mute = mute;
    w = 0;
    while (!tx_ready && w < 1000) begin @(negedge clk); w++; end
    if (!tx_ready) check("ready_wait", tx_ready, 1);
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    e.data = d; e.expect_done = ack && !mute; e.check_frame = !mute;
    exp_q.push_back(e);
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_clk_oe", ps2_clk_oe, 1);
    check("accept_ready_low", tx_ready, 0);
    tx_data = ~d;
    repeat (30) @(negedge clk);
    tx_valid = 1'b0;
    if (wait_done) begin
      w = 0;
      while (exp_q.size() != 0 && w < bound) begin @(negedge clk); w++; end
      if (exp_q.size() != 0) begin
        check("frame_completion_timeout", exp_q.size(), 0);
        exp_q.delete();
      end
      repeat (60) @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int w;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    dev_clk = 1'b1; dev_data = 1'b1; dev_ack = 1'b1; dev_mute = 1'b0;
    dev_stop_after = 99; bfm_halted = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    check("reset_err", tx_err, 0);
    check("reset_clk_oe", ps2_clk_oe, 0);
    check("reset_data_oe", ps2_data_oe, 0);
    @(negedge clk); rst_n = 1'b1;

    send(8'hED, 1, 0, 1, 3000);
    send(8'hF4, 1, 0, 1, 3000);
    send(8'hFF, 1, 0, 1, 3000);
    send(8'h3C, 0, 0, 1, 3000);
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) != 0), 0, 1, 3000);
    end

    // Abort mid-frame after four data bits.
    dev_stop_after = 4; bfm_halted = 1'b0;
    send(8'hA5, 1, 0, 0, 0);
    w = 0;
    while (!bfm_halted && w < 3000) begin @(negedge clk); w++; end
    check("abort_point_reached", bfm_halted, 1);
    check("abort_busy_before", busy, 1);
    pulse_reset();
    dev_stop_after = 99;
    repeat (20) @(negedge clk);
    send(8'hF4, 1, 0, 1, 3000);

`ifdef PS2_TX_TIMEOUT_EN
    send(8'hF4, 1, 1, 1, TMO_CYC + 2000);
`else
    send(8'hF4, 1, 1, 0, 0);
    repeat (2000) @(negedge clk);
    check("no_watchdog_busy", busy, 1);
    check("no_watchdog_pending", exp_q.size(), 1);
    pulse_reset();
`endif
    dev_mute = 1'b0;
    send(8'hED, 1, 0, 1, 3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

endmodule
